hdbn_encoder: RTL

Parametrised HDBn line encoder and successor to the fixed HDB3 B-insertion stage. Takes an NRZ bit stream qualified by a bit-enable strobe. Replaces every run of ZRUN zeros with a B..V substitution pattern and assigns AMI polarity, producing ternary pos/neg outputs. ZRUN sets the code: 4 gives HDB3, 3 gives B3ZS-like. A runtime AMI bypass mode is provided. Sits between the framer's serial NRZ output and the line driver.

---
 rtl/hdbn_pkg.sv | 17 +
 rtl/hdbn_polarity.sv | 53 +++++
 rtl/hdbn_encoder.sv | 85 ++++++++
 3 files changed

// File: rtl/hdbn_pkg.sv
// Shared symbol and polarity encodings for the HDBn line encoder.
// Also provides the legality check for the zero-run length.
package hdbn_pkg;

  localparam logic [1:0] SYM_ZERO = 2'b00;
  localparam logic [1:0] SYM_MARK = 2'b01;
  localparam logic [1:0] SYM_B    = 2'b10;
  localparam logic [1:0] SYM_V    = 2'b11;

  localparam logic POL_NEG = 1'b0;
  localparam logic POL_POS = 1'b1;

  function automatic bit zrun_legal(input int zrun);
    return (zrun >= 2) && (zrun <= 8);
  endfunction

endpackage

// File: rtl/hdbn_polarity.sv
// Registered AMI polarity stage. Marks and B pulses alternate polarity;
// V pulses repeat the last polarity so the receiver can spot them.
module hdbn_polarity
  import hdbn_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_en,
  input  logic [1:0] i_sym,
  output logic       o_pos,
  output logic       o_neg,
  output logic [1:0] o_sym
);

  logic       r_last_pol;
  logic       r_pos;
  logic       r_neg;
  logic [1:0] r_sym;
  logic       w_flip;

  assign w_flip = ~r_last_pol;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_last_pol <= POL_NEG;
      r_pos      <= 1'b0;
      r_neg      <= 1'b0;
      r_sym      <= SYM_ZERO;
    end else if (i_en) begin
      r_sym <= i_sym;
      case (i_sym)
        SYM_MARK, SYM_B: begin
          r_pos      <= (w_flip == POL_POS);
          r_neg      <= (w_flip == POL_NEG);
          r_last_pol <= w_flip;
        end
        SYM_V: begin
          r_pos <= (r_last_pol == POL_POS);
          r_neg <= (r_last_pol == POL_NEG);
        end
        default: begin
          r_pos <= 1'b0;
          r_neg <= 1'b0;
        end
      endcase
    end
  end

  assign o_pos = r_pos;
  assign o_neg = r_neg;
  assign o_sym = r_sym;

endmodule

// File: rtl/hdbn_encoder.sv
// HDBn line encoder: replaces each run of ZRUN zeros with a B..V pattern
// and drives ternary pos/neg pulses; ami_mode bypasses substitution.
module hdbn_encoder
  import hdbn_pkg::*;
#(
  parameter int ZRUN  = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             nrz_in,
  input  logic             ami_mode,
  output logic             out_valid,
  output logic [1:0]       out_sym,
  output logic             pos_out,
  output logic             neg_out,
  output logic [CNT_W-1:0] sub_cnt
);

  // Out-of-range run lengths fall back to HDB3.
  localparam int ZR = zrun_legal(ZRUN) ? ZRUN : 4;
  localparam int ZW = $clog2(ZR);
  localparam int PW = $clog2(ZR + 1);

  logic [1:0]       r_sr [ZR];
  logic [ZW-1:0]    r_zcnt;
  logic             r_parity;
  logic [PW-1:0]    r_prime;
  logic [CNT_W-1:0] r_sub_cnt;
  logic             r_out_valid;

  logic             w_sub;
  logic             w_ins_b;
  logic [1:0]       w_new_sym;

  assign w_sub     = en && !nrz_in && !ami_mode && (r_zcnt == ZW'(ZR - 1));
  assign w_ins_b   = w_sub && !r_parity;
  assign w_new_sym = nrz_in ? SYM_MARK : (w_sub ? SYM_V : SYM_ZERO);

  // out_valid is a one-cycle pulse on the cycle after a primed en; there is
  // no back-pressure, the line driver must take every symbol it is given.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < ZR; i++) r_sr[i] <= SYM_ZERO;
      r_zcnt      <= '0;
      r_parity    <= 1'b0;
      r_prime     <= '0;
      r_sub_cnt   <= '0;
      r_out_valid <= 1'b0;
    end else if (en) begin
      r_sr[0] <= w_new_sym;
      for (int i = 1; i < ZR; i++) r_sr[i] <= r_sr[i-1];
      // The oldest zero of the run becomes B when the mark count is even.
      if (w_ins_b) r_sr[ZR-1] <= SYM_B;

      if (nrz_in || w_sub || ami_mode) r_zcnt <= '0;
      else                             r_zcnt <= r_zcnt + 1'b1;

      if (w_sub)       r_parity <= 1'b0;
      else if (nrz_in) r_parity <= ~r_parity;

      if (w_sub && !(&r_sub_cnt)) r_sub_cnt <= r_sub_cnt + 1'b1;

      if (r_prime != PW'(ZR)) r_prime <= r_prime + 1'b1;
      r_out_valid <= (r_prime == PW'(ZR));
    end else begin
      r_out_valid <= 1'b0;
    end
  end

  hdbn_polarity u_polarity (
    .clk   (clk),
    .rst_n (rst_n),
    .i_en  (en),
    .i_sym (r_sr[ZR-1]),
    .o_pos (pos_out),
    .o_neg (neg_out),
    .o_sym (out_sym)
  );

  assign out_valid = r_out_valid;
  assign sub_cnt   = r_sub_cnt;

endmodule
